// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-key synchronizer and debouncer with press/release/long-press/auto-repeat pulses.
module key_debounce_multi #(
  parameter int   N_KEYS        = 4,
  parameter int   DEB_CYCLES    = 1_000_000,
  parameter int   LONG_CYCLES   = 50_000_000,
  parameter int   REPEAT_CYCLES = 10_000_000,
  parameter logic PRESS_LEVEL   = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_event
);
  localparam logic REL = ~PRESS_LEVEL;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = LONG_CYCLES > 1 ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DW-1:0] D_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {ST_REL, ST_HELD, ST_LONG} state_t;
  assign key_event = |{key_press, key_release, key_long, key_repeat};
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic s1, s2, lvl, press_q, rel_q, long_q, rep_q;
    logic diff, acc, acc_press, acc_rel, long_nxt, rep_nxt_p;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt;
    state_t st, st_nxt;
    assign diff      = s2 != lvl;
    assign acc       = diff && deb_cnt == D_MAX;
    assign acc_press = acc && s2 == PRESS_LEVEL;
    assign acc_rel   = acc && s2 != PRESS_LEVEL;
    assign key_state[i]   = lvl;
    assign key_press[i]   = press_q;
    assign key_release[i] = rel_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = rep_q;
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
        s1       <= REL;
        s2       <= REL;
        lvl      <= REL;
        deb_cnt  <= '0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        st       <= ST_REL;
      end else begin
        s1       <= key_in[i];
        s2       <= s1;
        lvl      <= acc ? s2 : lvl;
        deb_cnt  <= (!diff || acc) ? '0 : deb_cnt + 1'b1;
        press_q  <= acc_press;
        rel_q    <= acc_rel;
        long_q   <= long_nxt;
        rep_q    <= rep_nxt_p;
        hold_cnt <= hold_nxt;
        rep_cnt  <= rep_nxt;
        st       <= st_nxt;
      end
    // an accepted release takes priority over a long/repeat firing in the same cycle
    always_comb begin
      st_nxt    = st;
      hold_nxt  = hold_cnt;
      rep_nxt   = rep_cnt;
      long_nxt  = 1'b0;
      rep_nxt_p = 1'b0;
      case (st)
        ST_REL:
          if (acc_press) begin
            st_nxt   = ST_HELD;
            hold_nxt = '0;
          end
        ST_HELD:
          if (acc_rel) st_nxt = ST_REL;
          else if (hold_cnt == H_MAX) begin
            st_nxt   = ST_LONG;
            long_nxt = 1'b1;
            rep_nxt  = '0;
          end else hold_nxt = hold_cnt + 1'b1;
        ST_LONG:
          if (acc_rel) st_nxt = ST_REL;
          else if (REPEAT_CYCLES > 0) begin
            rep_nxt_p = rep_cnt == R_MAX;
            rep_nxt   = rep_cnt == R_MAX ? '0 : rep_cnt + 1'b1;
          end
        default: st_nxt = ST_REL;
      endcase
    end
  end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed checks of debounce, press/release, long-press, repeat and reset.
module tb_key_debounce_multi;
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key_in;
  logic [3:0] key_state, key_press, key_release, key_long, key_repeat;
  logic       key_event;
  int n_cmp = 0;
  int n_err = 0;

  key_debounce_multi #(
    .N_KEYS(4), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .PRESS_LEVEL(1'b0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .key_long(key_long),
    .key_repeat(key_repeat), .key_event(key_event)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    key_in  = 4'hF;
    repeat (3) tick;
    sys_rst = 1'b0;
    chk("rst_state", 32'(key_state), 32'hF);
    chk("rst_pulses", 32'({key_press, key_release, key_long, key_repeat, key_event}), 32'h0);
    // clean press and release on channel 0
    key_in[0] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick;
      chk("p0_state", 32'(key_state[0]), 32'(t < 6));
      chk("p0_press", 32'(key_press[0]), 32'(t == 6));
      chk("p0_event", 32'(key_event), 32'(t == 6));
    end
    key_in[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick;
      chk("r0_release", 32'(key_release[0]), 32'(t == 6));
      chk("r0_state", 32'(key_state[0]), 32'(t >= 6));
    end
    // bounce on channel 1: 3 low, 1 high, 3 low
    for (int t = 1; t <= 16; t++) begin
      key_in[1] = (t == 4 || t > 7);
      tick;
      chk("bounce_state", 32'(key_state), 32'hF);
      chk("bounce_event", 32'(key_event), 32'h0);
    end
    // simultaneous press and release on channels 0 and 3
    key_in = 4'b0110;
    for (int t = 1; t <= 7; t++) begin
      tick;
      chk("sim_press", 32'(key_press), t == 6 ? 32'h9 : 32'h0);
      chk("sim_state", 32'(key_state), t >= 6 ? 32'h6 : 32'hF);
    end
    key_in = 4'b1111;
    for (int t = 1; t <= 7; t++) begin
      tick;
      chk("sim_release", 32'(key_release), t == 6 ? 32'h9 : 32'h0);
    end
    // long press with repeats on channel 2
    key_in[2] = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick;
      chk("l2_press", 32'(key_press[2]), 32'(t == 6));
    end
    for (int t = 1; t <= 20; t++) begin
      tick;
      chk("l2_long", 32'(key_long[2]), 32'(t == 20));
      chk("l2_event", 32'(key_event), 32'(t == 20));
    end
    for (int t = 1; t <= 16; t++) begin
      tick;
      chk("l2_repeat", 32'(key_repeat[2]), 32'(t == 8 || t == 16));
      chk("l2_nolong", 32'(key_long[2]), 32'h0);
    end
    key_in[2] = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick;
      chk("l2_release", 32'(key_release[2]), 32'(t == 6));
      chk("l2_norepeat", 32'(key_repeat[2]), 32'h0);
    end
    // release accepted on the same edge the long press would fire
    key_in[1] = 1'b0;
    for (int t = 1; t <= 6; t++) tick;
    chk("rw_press", 32'(key_press[1]), 32'h1);
    for (int t = 1; t <= 24; t++) begin
      if (t == 15) key_in[1] = 1'b1;
      tick;
      chk("rw_release", 32'(key_release[1]), 32'(t == 20));
      chk("rw_nolong", 32'(key_long[1]), 32'h0);
    end
    // reset asserted mid-cycle while channel 2 shows its long pulse
    key_in[2] = 1'b0;
    for (int t = 1; t <= 26; t++) tick;
    #2;
    chk("pre_rst_long", 32'(key_long[2]), 32'h1);
    chk("pre_rst_state", 32'(key_state), 32'hB);
    sys_rst = 1'b1;
    #1;
    chk("async_state", 32'(key_state), 32'hF);
    chk("async_pulses", 32'({key_press, key_release, key_long, key_repeat, key_event}), 32'h0);
    tick;
    sys_rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick;
      chk("rr_press", 32'(key_press[2]), 32'(t == 6));
    end
    for (int t = 1; t <= 21; t++) begin
      tick;
      chk("rr_long", 32'(key_long[2]), 32'(t == 20));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
